// File: rtl/ps2_host_tx_if.sv
// Host-side command handshake for the PS/2 transmitter.
//   tx_data  : byte to send (master -> slave)
//   tx_valid : request, accepted when tx_valid && tx_ready
//   tx_ready : transmitter idle and able to accept
//   tx_done  : one-cycle pulse, frame sent and ACK seen
//   tx_error : one-cycle pulse, NACK or timeout
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;

  modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_error);
  modport slave  (input tx_data, tx_valid, output tx_ready, tx_done, tx_error);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Runs a full host request: clock inhibit, start bit, 8 data bits LSB first,
// odd parity, stop bit, then checks the device ACK on the 11th falling clock.
// Ports:
//   clk, resetn   : system clock, async active-low reset
//   tx            : command handshake (slave side)
//   ps2_clk_in    : raw PS/2 clock line level
//   ps2_dat_in    : raw PS/2 data line level
//   ps2_clk_oe    : 1 = pull PS/2 clock low
//   ps2_dat_oe    : 1 = pull PS/2 data low
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | lines released, tx_ready high, waiting for a request
// S_INHIBIT  | clock held low for INHIBIT_CYCLES
// S_REQ      | one cycle with clock and data low (start bit asserted)
// S_WAIT_ST  | clock released, data low, waiting for first device fall
// S_SHIFT    | falls 1..10 drive data bits, parity, then release for stop
// S_ACK      | waiting for fall 11, sample device ACK
// S_WAIT_IDL | waiting for both lines to return high
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        resetn,
  ps2_host_tx_if.slave tx,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic        ps2_clk_oe,
  output logic        ps2_dat_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] LD_INH  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] LD_TMO  = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_WAIT_ST, S_SHIFT, S_ACK, S_WAIT_IDL
  } state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_clk_sync, r_dat_sync;
  logic          r_clk_prev;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [3:0]    r_bitcnt;
  logic [CW-1:0] r_cnt;
  logic          r_dat_drv;

  logic w_sync_clk, w_sync_dat, w_fall, w_active, w_timeout;
  logic w_clk_oe, w_dat_oe, w_done, w_error;

  assign w_sync_clk = r_clk_sync[1];
  assign w_sync_dat = r_dat_sync[1];
  assign w_fall     = r_clk_prev & ~w_sync_clk;
  assign w_active   = (r_state == S_WAIT_ST) || (r_state == S_SHIFT) ||
                      (r_state == S_ACK)     || (r_state == S_WAIT_IDL);
  // Shared counter: counts down the inhibit, then reloads as the frame timeout.
  assign w_timeout  = w_active && (r_cnt == '0);

  // Synchronizers reset to the idle-high line level so no false fall appears.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
      r_dat_sync <= {r_dat_sync[0], ps2_dat_in};
      r_clk_prev <= w_sync_clk;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_clk_oe = 1'b0;
    w_dat_oe = 1'b0;
    w_done   = 1'b0;
    w_error  = 1'b0;
    case (r_state)
      S_IDLE:     if (tx.tx_valid) w_next = S_INHIBIT;
      S_INHIBIT: begin
        w_clk_oe = 1'b1;
        if (r_cnt == '0) w_next = S_REQ;
      end
      S_REQ: begin
        w_clk_oe = 1'b1;
        w_dat_oe = 1'b1;
        w_next   = S_WAIT_ST;
      end
      S_WAIT_ST: begin
        w_dat_oe = 1'b1;
        if (w_fall) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_dat_oe = r_dat_drv;
        // fall 10 arrives with nine falls already counted
        if (w_fall && (r_bitcnt == 4'd9)) w_next = S_ACK;
      end
      S_ACK: begin
        if (w_fall) begin
          if (w_sync_dat) begin
            w_error = 1'b1;
            w_next  = S_IDLE;
          end else begin
            w_next  = S_WAIT_IDL;
          end
        end
      end
      S_WAIT_IDL: begin
        if (w_sync_clk && w_sync_dat) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Timeout wins over any fall seen in the same cycle.
    if (w_timeout) begin
      w_next   = S_IDLE;
      w_clk_oe = 1'b0;
      w_dat_oe = 1'b0;
      w_done   = 1'b0;
      w_error  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bitcnt  <= '0;
      r_cnt     <= '0;
      r_dat_drv <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tx.tx_valid) begin
            r_shift  <= tx.tx_data;
            r_parity <= ~^tx.tx_data;
            r_cnt    <= LD_INH;
            r_bitcnt <= '0;
          end
        end
        S_INHIBIT: if (r_cnt != '0) r_cnt <= r_cnt - CNT_ONE;
        S_REQ:     r_cnt <= LD_TMO;
        default: begin
          if (w_active && (r_cnt != '0)) r_cnt <= r_cnt - CNT_ONE;
          if (w_fall && ((r_state == S_WAIT_ST) || (r_state == S_SHIFT))) begin
            if (r_bitcnt < 4'd8) begin
              r_dat_drv <= ~r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end else if (r_bitcnt == 4'd8) begin
              r_dat_drv <= ~r_parity;
            end else begin
              r_dat_drv <= 1'b0;
            end
            r_bitcnt <= r_bitcnt + 4'd1;
          end
        end
      endcase
    end
  end

  assign ps2_clk_oe  = w_clk_oe;
  assign ps2_dat_oe  = w_dat_oe;
  assign tx.tx_ready = (r_state == S_IDLE);
  assign tx.tx_done  = w_done;
  assign tx.tx_error = w_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device model.
// Timing parameters are scaled down so the run stays short; the device
// clock period is 2*HALF system cycles.
module tb_ps2_host_tx;
  localparam int INH  = 300;
  localparam int TMO  = 3000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;

  int passed = 0;
  int total  = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_rdy  = 0;

  ps2_host_tx_if ifc ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx         (ifc),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  // open-collector wired-AND of host and device
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifc.tx_done)  n_done++;
    if (ifc.tx_error) n_err++;
    if (ifc.tx_ready) n_rdy++;
  end

  task automatic send(input logic [7:0] d);
    ifc.tx_data  = d;
    ifc.tx_valid = 1'b1;
    @(negedge clk);
    ifc.tx_valid = 1'b0;
  endtask

  // Waits for the host start bit, then clocks nfalls times, sampling the
  // data line during each high phase (sample 0 is the start bit).
  task automatic device_frame(input int nfalls, input bit ack,
                              output logic [10:0] bits, output bit ok);
    ok = 1'b0;
    bits = '0;
    for (int i = 0; i < INH + 200; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_dat_oe) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    repeat (5) @(negedge clk);
    for (int k = 0; k < nfalls; k++) begin
      repeat (HALF/2) @(negedge clk);
      bits[k] = ps2_dat_in;
      if (k == 10 && ack) dev_dat = 1'b0;
      repeat (HALF/2) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
    end
    if (nfalls == 11) begin
      repeat (HALF/2) @(negedge clk);
      dev_dat = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (ifc.tx_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ifc.tx_ready); else passed++;
    total++; if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); else passed++;
    total++; if (ps2_dat_oe !== 1'b0) $display("FAIL reset_dat_oe got=%b exp=0", ps2_dat_oe); else passed++;
    total++; if ({ifc.tx_done, ifc.tx_error} !== 2'b00)
      $display("FAIL reset_pulses got=%b exp=00", {ifc.tx_done, ifc.tx_error}); else passed++;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frame(input logic [7:0] d, input logic [10:0] exp_bits, input string nm);
    logic [10:0] bits;
    bit ok;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    send(d);
    device_frame(11, 1'b1, bits, ok);
    total++; if (!ok) $display("FAIL %s_start got=no_start exp=start_bit", nm); else passed++;
    repeat (10) @(negedge clk);
    total++; if (bits !== exp_bits) $display("FAIL %s_bits got=%b exp=%b", nm, bits, exp_bits); else passed++;
    total++; if (n_done - d0 !== 1) $display("FAIL %s_done got=%0d exp=1", nm, n_done - d0); else passed++;
    total++; if (n_err - e0 !== 0) $display("FAIL %s_err got=%0d exp=0", nm, n_err - e0); else passed++;
    total++; if (ifc.tx_ready !== 1'b1) $display("FAIL %s_ready got=%b exp=1", nm, ifc.tx_ready); else passed++;
  endtask

  task automatic test_nack();
    logic [10:0] bits;
    bit ok;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    send(8'hFF);
    device_frame(11, 1'b0, bits, ok);
    repeat (10) @(negedge clk);
    total++; if (bits !== 11'b1_1_11111111_0) $display("FAIL nack_bits got=%b exp=%b", bits, 11'b1_1_11111111_0); else passed++;
    total++; if (n_err - e0 !== 1) $display("FAIL nack_err got=%0d exp=1", n_err - e0); else passed++;
    total++; if (n_done - d0 !== 0) $display("FAIL nack_done got=%0d exp=0", n_done - d0); else passed++;
    total++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00)
      $display("FAIL nack_oe got=%b exp=00", {ps2_clk_oe, ps2_dat_oe}); else passed++;
    total++; if (ifc.tx_ready !== 1'b1) $display("FAIL nack_ready got=%b exp=1", ifc.tx_ready); else passed++;
  endtask

  task automatic test_timeout();
    int n_inh, n_req, n;
    int d0, e0;
    bit hit;
    d0 = n_done; e0 = n_err;
    send(8'hF4);
    n_inh = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n_inh < INH + 50) begin n_inh++; @(negedge clk); end
    n_req = 0;
    while (ps2_clk_oe && ps2_dat_oe && n_req < 10) begin n_req++; @(negedge clk); end
    total++; if (n_inh !== INH) $display("FAIL tmo_inhibit_len got=%0d exp=%0d", n_inh, INH); else passed++;
    total++; if (n_req !== 1) $display("FAIL tmo_req_len got=%0d exp=1", n_req); else passed++;
    // current sample is the first WAIT_START cycle
    n = 0;
    hit = 1'b0;
    while (n < TMO + 100) begin
      @(negedge clk);
      n++;
      if (ifc.tx_error) begin hit = 1'b1; break; end
    end
    total++; if (!hit || n !== TMO) $display("FAIL tmo_len got=%0d exp=%0d", n, TMO); else passed++;
    total++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00)
      $display("FAIL tmo_release got=%b exp=00", {ps2_clk_oe, ps2_dat_oe}); else passed++;
    repeat (3) @(negedge clk);
    total++; if (n_err - e0 !== 1 || n_done - d0 !== 0)
      $display("FAIL tmo_pulses got=err%0d/done%0d exp=err1/done0", n_err - e0, n_done - d0); else passed++;
    total++; if (ifc.tx_ready !== 1'b1) $display("FAIL tmo_ready got=%b exp=1", ifc.tx_ready); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    bit ok;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    send(8'hED);
    device_frame(4, 1'b0, bits, ok);
    total++; if (ifc.tx_ready !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", ifc.tx_ready); else passed++;
    #2 resetn = 1'b0;
    #1;
    total++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00)
      $display("FAIL rstmid_oe got=%b exp=00", {ps2_clk_oe, ps2_dat_oe}); else passed++;
    total++; if (ifc.tx_ready !== 1'b1) $display("FAIL rstmid_ready got=%b exp=1", ifc.tx_ready); else passed++;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (n_done - d0 !== 0 || n_err - e0 !== 0)
      $display("FAIL rstmid_pulses got=done%0d/err%0d exp=0/0", n_done - d0, n_err - e0); else passed++;
    test_frame(8'hED, 11'b1_1_11101101_0, "rstmid_ed");
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    bit ok;
    int d0, e0, r0;
    d0 = n_done; e0 = n_err;
    ifc.tx_data  = 8'hAA;
    ifc.tx_valid = 1'b1;
    @(negedge clk);
    r0 = n_rdy;
    fork
      device_frame(11, 1'b1, bits, ok);
      begin
        repeat (INH + 200) @(negedge clk);
        ifc.tx_data = 8'h55;
      end
    join
    total++; if (bits !== 11'b1_1_10101010_0) $display("FAIL b2b_first_bits got=%b exp=%b", bits, 11'b1_1_10101010_0); else passed++;
    total++; if (n_rdy - r0 !== 0) $display("FAIL b2b_ready_busy got=%0d exp=0", n_rdy - r0); else passed++;
    device_frame(11, 1'b1, bits, ok);
    ifc.tx_valid = 1'b0;
    total++; if (bits !== 11'b1_1_01010101_0) $display("FAIL b2b_second_bits got=%b exp=%b", bits, 11'b1_1_01010101_0); else passed++;
    repeat (10) @(negedge clk);
    total++; if (n_done - d0 !== 2 || n_err - e0 !== 0)
      $display("FAIL b2b_pulses got=done%0d/err%0d exp=2/0", n_done - d0, n_err - e0); else passed++;
    total++; if (ifc.tx_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", ifc.tx_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_frame(8'hED, 11'b1_1_11101101_0, "ed");
    test_frame(8'h01, 11'b1_0_00000001_0, "x01");
    test_frame(8'h00, 11'b1_1_00000000_0, "x00");
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
